// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, flush-to-bubble and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned        CTRL_W   = 6,
  parameter int unsigned        PC_W     = 9,
  parameter int unsigned        INST_W   = 32,
  parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0020,
  parameter bit                 SKID     = 1'b1,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PC_W-1:0]   in_pc_4,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PC_W-1:0]   out_pc_4,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [PC_W-1:0]     m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [INST_W-1:0]   m_inst_q, m_inst_d, s_inst_q, s_inst_d;
  logic                acc, pop;

  // State register; payload registers carry no reset, validity lives in state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
    m_ctrl_q <= m_ctrl_d;
    m_pc_q   <= m_pc_d;
    m_inst_q <= m_inst_d;
    s_ctrl_q <= s_ctrl_d;
    s_pc_q   <= s_pc_d;
    s_inst_q <= s_inst_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_pc_d   = m_pc_q;
    m_inst_d = m_inst_q;
    s_ctrl_d = s_ctrl_q;
    s_pc_d   = s_pc_q;
    s_inst_d = s_inst_q;
    acc      = in_valid & in_ready;
    pop      = out_valid & out_ready;

    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          state_d  = ONE;
          m_ctrl_d = in_ctrl;
          m_pc_d   = in_pc_4;
          m_inst_d = in_inst;
        end
      end
      ONE: begin
        // Without a skid entry, acc in ONE implies out_ready and hence pop.
        if (acc && pop) begin
          m_ctrl_d = in_ctrl;
          m_pc_d   = in_pc_4;
          m_inst_d = in_inst;
        end else if (acc) begin
          state_d  = TWO;
          s_ctrl_d = in_ctrl;
          s_pc_d   = in_pc_4;
          s_inst_d = in_inst;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d  = ONE;
          m_ctrl_d = s_ctrl_q;
          m_pc_d   = s_pc_q;
          m_inst_d = s_inst_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) state_d = EMPTY;

    rdy_d = (state_d != TWO);

    cnt_d = cnt_q;
    if (!out_valid && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Output logic
  always_comb begin
    out_valid  = (state_q != EMPTY);
    out_ctrl   = out_valid ? m_ctrl_q : '0;
    out_pc_4   = out_valid ? m_pc_q   : '0;
    out_inst   = out_valid ? m_inst_q : NOP_INST;
    in_ready   = SKID ? rdy_q : (!out_valid | out_ready);
    bubble_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives three pipe_stage_reg variants (skid, no-skid, 3-bit counter) from
// shared stimulus and compares each against a queue-style occupancy model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [5:0]  c;
    logic [8:0]  p;
    logic [31:0] i;
  } ent_t;

  localparam logic [31:0] NOP = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [5:0]  in_ctrl;
  logic [8:0]  in_pc_4;
  logic [31:0] in_inst;

  logic        dv [3];
  logic        dr [3];
  logic [5:0]  dc [3];
  logic [8:0]  dp [3];
  logic [31:0] di [3];
  logic [15:0] db [3];
  logic [2:0]  b2;

  int checks = 0;
  int errors = 0;

  ent_t q  [3][2];
  int   n  [3] = '{0, 0, 0};
  int   bc [3] = '{0, 0, 0};
  int   bmax [3] = '{65535, 65535, 7};
  bit   skd  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(16)) u_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(dr[0]),
    .in_ctrl(in_ctrl), .in_pc_4(in_pc_4), .in_inst(in_inst),
    .out_valid(dv[0]), .out_ready(out_ready), .out_ctrl(dc[0]),
    .out_pc_4(dp[0]), .out_inst(di[0]), .bubble_cnt(db[0]));

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(dr[1]),
    .in_ctrl(in_ctrl), .in_pc_4(in_pc_4), .in_inst(in_inst),
    .out_valid(dv[1]), .out_ready(out_ready), .out_ctrl(dc[1]),
    .out_pc_4(dp[1]), .out_inst(di[1]), .bubble_cnt(db[1]));

  pipe_stage_reg #(.SKID(1'b1), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(dr[2]),
    .in_ctrl(in_ctrl), .in_pc_4(in_pc_4), .in_inst(in_inst),
    .out_valid(dv[2]), .out_ready(out_ready), .out_ctrl(dc[2]),
    .out_pc_4(dp[2]), .out_inst(di[2]), .bubble_cnt(b2));

  assign db[2] = {13'b0, b2};

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input ent_t e);
    in_valid = v;
    in_ctrl  = e.c;
    in_pc_4  = e.p;
    in_inst  = e.i;
  endtask

  // One clock: compare pre-edge outputs with the model, then advance the model.
  task automatic cycle(input bit do_chk);
    bit   acc [3];
    bit   pop [3];
    bit   rdy;
    ent_t eo;
    ent_t ein;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      rdy    = skd[d] ? (n[d] < 2) : (n[d] == 0 || out_ready);
      acc[d] = in_valid && rdy;
      pop[d] = (n[d] > 0) && out_ready;
      eo     = (n[d] > 0) ? q[d][0] : '{c: 6'd0, p: 9'd0, i: NOP};
      if (do_chk) begin
        chk("out_valid", d, 64'(dv[d]), 64'(n[d] > 0));
        chk("in_ready",  d, 64'(dr[d]), 64'(rdy));
        chk("out_ctrl",  d, 64'(dc[d]), 64'(eo.c));
        chk("out_pc_4",  d, 64'(dp[d]), 64'(eo.p));
        chk("out_inst",  d, 64'(di[d]), 64'(eo.i));
        chk("bubble",    d, 64'(db[d]), 64'(bc[d]));
      end
    end
    ein = '{c: in_ctrl, p: in_pc_4, i: in_inst};
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        n[d]  = 0;
        bc[d] = 0;
      end else begin
        if (n[d] == 0 && bc[d] < bmax[d]) bc[d]++;
        if (flush) n[d] = 0;
        else begin
          if (pop[d]) begin
            q[d][0] = q[d][1];
            n[d]--;
          end
          if (acc[d]) begin
            q[d][n[d]] = ein;
            n[d]++;
          end
        end
      end
    end
    #1;
  endtask

  ent_t ea, eb, ec, ed;
  ent_t stream [3];

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);

    // Reset / idle
    cycle(1'b0);
    cycle(1'b1);
    rst = 1'b0;
    repeat (5) cycle(1'b1);
    chk("idle_cnt",   0, 64'(db[0]), 64'd5);
    chk("idle_cnt",   2, 64'(db[2]), 64'd5);
    chk("idle_inst",  0, 64'(di[0]), 64'h20);
    chk("idle_ready", 0, 64'(dr[0]), 64'd1);

    // Streaming with out_ready=1
    stream[0] = '{c: 6'h2B, p: 9'h004, i: 32'h8C22_0004};
    stream[1] = '{c: 6'h06, p: 9'h008, i: 32'hAC23_0008};
    stream[2] = '{c: 6'h31, p: 9'h00C, i: 32'h0043_2020};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, stream[k]);
      cycle(1'b1);
      chk("stream_inst", 0, 64'(di[0]), 64'(stream[k].i));
    end
    drive(1'b0, '0);
    repeat (3) cycle(1'b1);

    // Backpressure on the skid variant
    ea = '{c: 6'h11, p: 9'h010, i: 32'h1111_0001};
    eb = '{c: 6'h22, p: 9'h014, i: 32'h2222_0002};
    ec = '{c: 6'h33, p: 9'h018, i: 32'h3333_0003};
    out_ready = 1'b0;
    drive(1'b1, ea); cycle(1'b1);
    drive(1'b1, eb); cycle(1'b1);
    drive(1'b1, ec); repeat (3) cycle(1'b1);
    chk("bp_ready", 0, 64'(dr[0]), 64'd0);
    chk("bp_hold",  0, 64'(di[0]), 64'(ea.i));
    out_ready = 1'b1;
    repeat (2) cycle(1'b1);
    drive(1'b0, '0);
    repeat (3) cycle(1'b1);

    // Flush while two entries are held; D must be dropped
    ed = '{c: 6'h3F, p: 9'h1FC, i: 32'hDDDD_DDDD};
    out_ready = 1'b0;
    drive(1'b1, ea); cycle(1'b1);
    drive(1'b1, eb); cycle(1'b1);
    drive(1'b1, ed); flush = 1'b1; cycle(1'b1);
    flush = 1'b0; drive(1'b0, '0);
    chk("flush_valid", 0, 64'(dv[0]), 64'd0);
    chk("flush_ctrl",  0, 64'(dc[0]), 64'd0);
    chk("flush_inst",  0, 64'(di[0]), 64'h20);
    chk("flush_ready", 0, 64'(dr[0]), 64'd1);
    out_ready = 1'b1;
    repeat (3) cycle(1'b1);

    // Combinational in_ready on the no-skid variant
    out_ready = 1'b0;
    drive(1'b1, ea); cycle(1'b1);
    drive(1'b1, eb);
    #1 chk("ns_ready_lo", 1, 64'(dr[1]), 64'd0);
    out_ready = 1'b1;
    #1 chk("ns_ready_hi", 1, 64'(dr[1]), 64'd1);
    cycle(1'b1);
    chk("ns_replace", 1, 64'(di[1]), 64'(eb.i));
    drive(1'b0, '0);
    repeat (2) cycle(1'b1);

    // Saturation of the 3-bit counter
    rst = 1'b1; cycle(1'b1);
    rst = 1'b0;
    repeat (10) cycle(1'b1);
    chk("sat_cnt", 2, 64'(db[2]), 64'd7);
    flush = 1'b1; cycle(1'b1);
    flush = 1'b0; cycle(1'b1);
    chk("sat_flush", 2, 64'(db[2]), 64'd7);
    rst = 1'b1; cycle(1'b1);
    rst = 1'b0;
    chk("sat_rst", 2, 64'(db[2]), 64'd0);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom % 4) != 0, ent_t'({$urandom, $urandom}));
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 20) == 0;
      rst       = ($urandom % 97) == 0;
      cycle(1'b1);
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0);
    repeat (4) cycle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS core. It is the successor to the fixed ID/EX, EX/MEM and MEM/WB latches.
- Carries a control bundle, the PC+4 and the instruction word between stages, using a valid/ready handshake in place of a bare stall.
- Has an optional 2-entry skid buffer, so upstream ready is fully registered, plus flush-to-bubble with NOP injection.
- Includes a saturating bubble counter for pipeline performance debug.

Parameters:
- CTRL_W, 6: width of control bundle (memread, memwrite, memtoreg, regwrite, regdst, link, ...).
- PC_W, 9: width of PC+4 field.
- INST_W, 32: instruction word width.
- NOP_INST, 32'h0000_0020: instruction word driven for bubbles.
- SKID, 1: 1 = two-entry skid buffer (in_ready registered); 0 = single entry (in_ready combinational).
- CNT_W, 16: bubble counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all held entries and the current input; stage becomes bubble
- in_valid  in  1  upstream stage presents an entry
- in_ready  out  1  stage can accept an entry this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_pc_4  in  PC_W  upstream PC+4
- in_inst  in  INST_W  upstream instruction
- out_valid  out  1  out_* hold a real entry
- out_ready  in  1  downstream accepts the entry
- out_ctrl  out  CTRL_W  control bundle; forced 0 when out_valid=0
- out_pc_4  out  PC_W  PC+4; forced 0 when out_valid=0
- out_inst  out  INST_W  instruction; NOP_INST when out_valid=0
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0 after reset

Behaviour:
- Storage: main entry M, which drives the out_* ports, and skid entry S, which exists only when SKID=1.
- State (SKID=1), with occupancy encoding:
  - EMPTY: no entries.
  - ONE: M valid.
  - TWO: M and S valid.
- Transfer rules:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Transitions (no flush):
  - EMPTY: acc -> ONE (M<=in).
  - ONE: acc&pop -> ONE (M<=in). acc&!pop -> TWO (S<=in). !acc&pop -> EMPTY.
  - TWO: pop -> ONE (M<=S). acc is impossible in TWO.
- in_ready (SKID=1) = register, 1 in EMPTY/ONE, 0 in TWO. It has no combinational path from out_ready.
- SKID=0 (states EMPTY and ONE only): in_ready = !M_valid | out_ready, which is combinational.
- Latency: an accepted entry appears on out_* the cycle after acceptance (1 cycle) when the stage was EMPTY, or when in ONE with a same-cycle pop.
- Order is preserved: S never bypasses M.
- Data on out_* must hold stable while out_valid=1 & out_ready=0.
- Flush (highest priority after rst):
  - Next state is EMPTY; M and S are invalidated.
  - The entry presented this cycle is dropped even if in_valid=1.
  - in_ready=1 the following cycle.
  - A pop in the flush cycle still completes; downstream sees the current entry.
- Bubble outputs: whenever out_valid=0, out_ctrl=0, out_pc_4=0, out_inst=NOP_INST. Downstream therefore never writes regs or memory from a bubble.
- bubble_cnt:
  - Increments by 1 in every cycle with out_valid=0 (sampled pre-edge).
  - Saturates at 2^CNT_W-1 with no wrap.
  - Reset to 0 by rst only; flush does not clear it.
- Reset values (rst=1 at a clock edge):
  - State EMPTY; out_valid=0; out_ctrl=0; out_pc_4=0; out_inst=NOP_INST; bubble_cnt=0.
  - in_ready=1 (SKID=1: registered, set to 1).
  - Reset mid-transfer discards all entries; rst overrides flush and handshakes.
- Simultaneous flush & rst: reset behaviour applies.

Test Plan:
- Reset / idle: assert rst 2 cycles, then idle 5 cycles -> out_valid=0, out_inst=32'h0000_0020, out_ctrl=0, in_ready=1, bubble_cnt=5.
- Streaming, out_ready=1: feed inst 0x8C220004, 0xAC230008, 0x00432020 back-to-back -> out_valid=1 for 3 consecutive cycles, each 1 cycle after acceptance, in order, with matching ctrl and pc_4 (e.g. 9'h004, 9'h008, 9'h00C).
- Backpressure (SKID=1):
  - Hold out_ready=0 and push 3 entries -> A and B accepted, in_ready=0 from the cycle after B is accepted, C is held upstream; out_* stay at A.
  - Release out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush while TWO: entries A, B held, flush=1 with in_valid=1 (entry D) -> next cycle out_valid=0, out_ctrl=0, out_inst=NOP, in_ready=1; D never appears at the output.
- SKID=0 instance: out_ready=0 with M valid -> in_ready=0 in the same cycle. Raise out_ready -> in_ready=1 combinationally, and the new entry replaces M at the next edge.
- Saturation, CNT_W=3: idle 10 cycles after reset -> bubble_cnt reaches 7 and holds 7; a flush does not clear it, and rst returns it to 0.
